// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants, log2 helper and next-PC select type for the PC unit
package pc_pkg;

    localparam int          DEF_WIDTH        = 32;
    localparam int          DEF_INC          = 4;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;

    // Exact log2 for the power-of-two increment; result is the number of alignment bits.
    function automatic int log2_inc(input int inc);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) == inc) begin
                r = i;
            end
        end
        return r;
    endfunction

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_EXC,
        SEL_JUMP,
        SEL_BRANCH,
        SEL_PENDING,
        SEL_HOLD,
        SEL_INC
    } pc_sel_e;

endpackage

// File: rtl/pc_incrementor.sv
// rtl/pc_incrementor.sv - WIDTH-bit constant adder producing PC + INC, carry discarded
module pc_incrementor #(
    parameter int WIDTH = 32,
    parameter int INC   = 4
) (
    input  logic [WIDTH-1:0] pc_i,
    output logic [WIDTH-1:0] sum_o
);

    assign sum_o = pc_i + WIDTH'(INC);

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with priority next-PC select and a one-entry redirect queue
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter int               INC          = DEF_INC,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Exception,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCAddResult,
    output logic             RedirectPending,
    output logic             MisalignErr
);

    localparam int               ALIGN_BITS = log2_inc(INC);
    localparam logic [WIDTH-1:0] LOW_MASK   = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             pend_q, pend_d;
    logic             mis_q, mis_d;
    logic [WIDTH-1:0] req_tgt, req_aligned;
    logic             req_valid;
    pc_sel_e          sel;

    pc_incrementor #(.WIDTH(WIDTH), .INC(INC)) u_inc (
        .pc_i  (pc_q),
        .sum_o (PCAddResult)
    );

    assign req_valid   = Jump | BranchTaken;
    assign req_tgt     = Jump ? JumpTarget : BranchTarget;
    assign req_aligned = req_tgt & ~LOW_MASK;

    always_comb begin
        sel = SEL_INC;
        if (Exception) begin
            sel = SEL_EXC;
        end else if (Stall) begin
            sel = SEL_HOLD;
        end else if (Jump) begin
            sel = SEL_JUMP;
        end else if (BranchTaken) begin
            sel = SEL_BRANCH;
        end else if (pend_q) begin
            sel = SEL_PENDING;
        end
    end

    always_comb begin
        pc_d       = PCAddResult;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        // A target is accepted whether it goes straight to PC or into the queue.
        mis_d      = !Exception && req_valid && ((req_tgt & LOW_MASK) != '0);
        case (sel)
            SEL_RESET:   pc_d = RESET_VECTOR;
            SEL_EXC: begin
                pc_d       = EXC_VECTOR;
                pend_d     = 1'b0;
                pend_tgt_d = '0;
            end
            SEL_HOLD: begin
                pc_d = pc_q;
                if (req_valid) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = req_aligned;
                end
            end
            SEL_JUMP, SEL_BRANCH: begin
                pc_d       = req_aligned;
                pend_d     = 1'b0;
                pend_tgt_d = '0;
            end
            SEL_PENDING: begin
                pc_d   = pend_tgt_q;
                pend_d = 1'b0;
            end
            default:     pc_d = PCAddResult;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q       <= RESET_VECTOR;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            mis_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            mis_q      <= mis_d;
        end
    end

    assign PC              = pc_q;
    assign RedirectPending = pend_q;
    assign MisalignErr     = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed and randomized checks of pc_unit against a behavioural model
module tb_pc_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 1'b0;
    logic        Exception = 1'b0;
    logic        Jump = 1'b0;
    logic [31:0] JumpTarget = '0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic [31:0] PC;
    logic [31:0] PCAddResult;
    logic        RedirectPending;
    logic        MisalignErr;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_tgt;
    logic        m_mis;

    pc_unit dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Stall           (Stall),
        .Exception       (Exception),
        .Jump            (Jump),
        .JumpTarget      (JumpTarget),
        .BranchTaken     (BranchTaken),
        .BranchTarget    (BranchTarget),
        .PC              (PC),
        .PCAddResult     (PCAddResult),
        .RedirectPending (RedirectPending),
        .MisalignErr     (MisalignErr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_pc"}, PC, m_pc);
        chk({tag, "_add"}, PCAddResult, m_pc + 32'd4);
        chk({tag, "_pend"}, {31'd0, RedirectPending}, {31'd0, m_pend});
        chk({tag, "_mis"}, {31'd0, MisalignErr}, {31'd0, m_mis});
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_pend = 1'b0;
        m_tgt  = 32'h0;
        m_mis  = 1'b0;
    endtask

    // Drive one cycle at the falling edge, advance the model, check at the next falling edge.
    task automatic step(input string tag, input logic st, input logic ex,
                        input logic jp, input logic [31:0] jt,
                        input logic br, input logic [31:0] bt);
        logic [31:0] raw, aligned;
        Stall = st; Exception = ex; Jump = jp; JumpTarget = jt;
        BranchTaken = br; BranchTarget = bt;
        raw     = jp ? jt : bt;
        aligned = raw - (raw % 32'd4);
        m_mis   = !ex && (jp || br) && (raw % 32'd4 != 0);
        if (ex) begin
            m_pc = 32'h180; m_pend = 1'b0;
        end else if (st) begin
            if (jp || br) begin
                m_pend = 1'b1; m_tgt = aligned;
            end
        end else if (jp || br) begin
            m_pc = aligned; m_pend = 1'b0;
        end else if (m_pend) begin
            m_pc = m_tgt; m_pend = 1'b0;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        @(negedge Clk);
        chk_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 Reset = 1'b0;
        #1;
        model_reset();
        chk({tag, "_pc"}, PC, 32'h0);
        chk({tag, "_pend"}, {31'd0, RedirectPending}, 32'd0);
        chk({tag, "_mis"}, {31'd0, MisalignErr}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge Clk);
        chk_all("rst");
        Reset = 1'b1;

        // Free-running increment from the reset vector
        for (int i = 0; i < 4; i++) step("inc", 0, 0, 0, 0, 0, 0);
        chk("t1_pc10", PC, 32'h10);

        // Stall with a branch queued on the second stall cycle
        step("t2a", 1, 0, 0, 0, 0, 0);
        step("t2b", 1, 0, 0, 0, 1, 32'h40);
        chk("t2_pend", {31'd0, RedirectPending}, 32'd1);
        step("t2c", 1, 0, 0, 0, 0, 0);
        chk("t2_hold", PC, 32'h10);
        step("t2d", 0, 0, 0, 0, 0, 0);
        chk("t2_tgt", PC, 32'h40);
        step("t2e", 0, 0, 0, 0, 0, 0);
        chk("t2_next", PC, 32'h44);

        // Jump beats branch, direct and queued
        step("t3a", 0, 0, 1, 32'h100, 1, 32'h200);
        chk("t3_direct", PC, 32'h100);
        step("t3b", 1, 0, 1, 32'h100, 1, 32'h200);
        step("t3c", 0, 0, 0, 0, 0, 0);
        chk("t3_queued", PC, 32'h100);

        // Exception during stall flushes the queue
        step("t4a", 1, 0, 0, 0, 1, 32'h40);
        step("t4b", 1, 1, 0, 0, 0, 0);
        chk("t4_exc", PC, 32'h180);
        step("t4c", 0, 0, 0, 0, 0, 0);
        chk("t4_after", PC, 32'h184);

        // Misaligned jump target
        step("t5a", 0, 0, 1, 32'h103, 0, 0);
        chk("t5_mis", {31'd0, MisalignErr}, 32'd1);
        step("t5b", 0, 0, 0, 0, 0, 0);
        chk("t5_mis_clr", {31'd0, MisalignErr}, 32'd0);

        // Wrap-around then asynchronous reset
        step("t6a", 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        chk("t6_add0", PCAddResult, 32'h0);
        step("t6b", 0, 0, 0, 0, 0, 0);
        chk("t6_wrap", PC, 32'h0);
        step("t6c", 0, 0, 0, 0, 0, 0);
        async_reset("t6_rst");

        // Reset while a redirect is queued discards it
        step("t7a", 1, 0, 1, 32'h800, 0, 0);
        async_reset("t7_rst");
        step("t7b", 0, 0, 0, 0, 0, 0);
        chk("t7_noq", PC, 32'h4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic st, ex, jp, br;
            st = ($urandom_range(0, 2) == 0);
            ex = ($urandom_range(0, 15) == 0);
            jp = ($urandom_range(0, 5) == 0);
            br = ($urandom_range(0, 4) == 0);
            step("rnd", st, ex, jp, $urandom, br, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
